mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Sits downstream of the EX-stage operand path, beside the single-cycle ALU. It takes the same X/Y operands and the MULT/MULTU/DIV/DIVU/MTHI/MTLO commands off the ALU's combinational path.
- Raises busy so the pipeline control stalls any MFHI/MFLO or new mult/div until the result is committed.

---
 rtl/mdu_hilo.sv | 191 +++++++++++++++++++
 tb/tb_mdu_hilo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Optional feature macro MDU_CANCEL_EN adds a cancel input that flushes an in-flight op.
module mdu_hilo #(
  parameter int unsigned MUL_FAST = 0,
  parameter int unsigned ITER     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] X,
  input  logic [31:0] Y,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [63:0]     acc_q, acc_d;
  logic [31:0]     opb_q, opb_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic            is_signed;
  logic [31:0]     x_mag, y_mag;
  logic [32:0]     mul_sum;
  logic [32:0]     div_diff;
  logic [63:0]     prod_fix;
  logic [31:0]     quo_fix, rem_fix;

  // MULT and DIV are the even opcodes of the mult/div group.
  assign is_signed = ~op[0];
  assign x_mag     = (is_signed && X[31]) ? -X : X;
  assign y_mag     = (is_signed && Y[31]) ? -Y : Y;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_diff = acc_q[63:31] - {1'b0, opb_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  // A zero divisor leaves the dividend magnitude as remainder, so the normal
  // remainder sign fix already reproduces X; only the quotient needs forcing.
  assign quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_res_q ? -acc_q[31:0] : acc_q[31:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              is_div_d  = op[1];
              neg_res_d = is_signed & (X[31] ^ Y[31]);
              neg_rem_d = is_signed & X[31];
              dz_d      = op[1] & (Y == 32'd0);
              cnt_d     = '0;
              if (op[1]) begin
                opb_d   = y_mag;
                acc_d   = {32'd0, x_mag};
                state_d = StRun;
              end else if (MUL_FAST != 0) begin
                opb_d   = x_mag;
                acc_d   = 64'(x_mag) * 64'(y_mag);
                state_d = StFix;
              end else begin
                opb_d   = x_mag;
                acc_d   = {32'd0, y_mag};
                state_d = StRun;
              end
            end
            OpMthi:  hi_d = X;
            OpMtlo:  lo_d = X;
            default: ;
          endcase
        end
      end

      StRun: begin
        if (is_div_q) begin
          // Restoring step: keep the shifted remainder when the trial subtract goes negative.
          acc_d = div_diff[32] ? {acc_q[62:0], 1'b0}
                               : {div_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end

      default: state_d = StIdle;
    endcase

`ifdef MDU_CANCEL_EN
    if (cancel && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed/scoreboarded bench for mdu_hilo; cancel scenarios run when MDU_CANCEL_EN is defined.
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] X;
  logic [31:0] Y;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  mdu_hilo #(
    .MUL_FAST (0),
    .ITER     (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .X           (X),
    .Y           (Y),
`ifdef MDU_CANCEL_EN
    .cancel      (cancel),
`endif
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [2:0] o,
                                 input logic [31:0] xv, input logic [31:0] yv);
    exp_t        e;
    longint      sx, sy, p;
    logic [63:0] up;
    sx = longint'($signed(xv));
    sy = longint'($signed(yv));
    e.tag = tag;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    case (o)
      3'd0: begin
        p    = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'd1: begin
        up   = {32'd0, xv} * {32'd0, yv};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (yv == 32'd0) begin
          e.lo  = 32'hFFFF_FFFF;
          e.hi  = xv;
          e.dbz = 1'b1;
        end else if (o == 3'd2) begin
          p    = sx / sy;
          e.lo = p[31:0];
          p    = sx % sy;
          e.hi = p[31:0];
        end else begin
          e.lo = xv / yv;
          e.hi = xv % yv;
        end
      end
    endcase
    return e;
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                          input logic dbz);
    exp_t e;
    e.tag = tag;
    e.hi  = hi;
    e.lo  = lo;
    e.dbz = dbz;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] xv, input logic [31:0] yv);
    start = 1'b1;
    op    = o;
    X     = xv;
    Y     = yv;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd6;
    X     = $urandom;
    Y     = $urandom;
  endtask

  // lat > 0 also checks cycles-to-done and busy cycles from the issue point.
  task automatic wait_result(input int lat);
    int   n;
    int   nb;
    exp_t e;
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) nb++;
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_done"}, 32'(done), 32'd1);
      check({e.tag, "_hi"}, HI, e.hi);
      check({e.tag, "_lo"}, LO, e.lo);
      check({e.tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
      if (lat > 0) begin
        check({e.tag, "_latency"}, 32'(n), 32'(lat));
        check({e.tag, "_busy_cycles"}, 32'(nb), 32'(lat));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd6;
    X     = '0;
    Y     = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    #12;
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MTHI / MTLO in idle, then a no-op opcode
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_done", 32'(done), 32'd0);
    check("mthi_busy", 32'(busy), 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);
    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nop_hi", HI, 32'h1234_5678);
    check("nop_lo", LO, 32'h9ABC_DEF0);
    check("nop_busy", 32'(busy), 32'd0);

    // MULT -3 * 5
    push_exp("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_result(33);

    // DIVU 100/7 with an MTLO dropped while busy
    push_exp("divu_100_7", 32'd2, 32'd14, 1'b0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'd5;
    X     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd6;
    check("mtlo_busy_still_busy", 32'(busy), 32'd1);
    wait_result(-1);

    // DIV -7/2 started in the done cycle
    push_exp("div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("b2b_done_dropped", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_result(33);

    // Divide by zero, and the pulse lasting one cycle
    push_exp("div_5_0", 32'd5, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'd5, 32'd0);
    wait_result(33);
    @(posedge clk);
    #1;
    check("dbz_pulse_end", 32'(div_by_zero), 32'd0);
    check("done_pulse_end", 32'(done), 32'd0);

    push_exp("div_min_neg1", 32'd0, 32'h8000_0000, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(33);

    // Reset aborts an in-flight MULTU
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(33);

    // Random mix against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = 3'(i % 4);
      a = $urandom;
      b = $urandom;
      if (i == 6) begin
        a = 32'hFFFF_FFFB;
        b = 32'd0;
      end
      if (i == 7) b = 32'd0;
      if (i == 3) b = 32'(b[7:0]) + 32'd1;
      sb.push_back(model($sformatf("rand%0d", i), o, a, b));
      issue(o, a, b);
      wait_result(33);
    end

`ifdef MDU_CANCEL_EN
    issue(3'd4, 32'hA5A5_A5A5, 32'd0);
    issue(3'd5, 32'hA5A5_A5A5, 32'd0);
    issue(3'd3, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_done", 32'(done), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) seen++;
      end
      check("cancel_no_done", 32'(seen), 32'd0);
    end
    check("cancel_hi", HI, 32'hA5A5_A5A5);
    check("cancel_lo", LO, 32'hA5A5_A5A5);

    // Cancel together with start in idle: start wins
    sb.push_back(model("cancel_start", 3'd1, 32'd7, 32'd6));
    cancel = 1'b1;
    issue(3'd1, 32'd7, 32'd6);
    cancel = 1'b0;
    check("cancel_start_busy", 32'(busy), 32'd1);
    wait_result(33);
    sb.push_back(model("cancel_b2b", 3'd2, 32'hFFFF_FC18, 32'd3));
    issue(3'd2, 32'hFFFF_FC18, 32'd3);
    check("cancel_b2b_busy", 32'(busy), 32'd1);
    wait_result(33);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
